// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator.
// Takes one raster-order pixel per valid cycle. Two line buffers hold the
// previous two rows, and a 3x3 register window feeds the filter stage.
// Only valid-convolution windows are produced (no padding, no backpressure).
module conv_window_gen #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pixel_valid,
   input  logic [DATA_W-1:0] pixel_in,
   output logic [DATA_W-1:0] win_0,
   output logic [DATA_W-1:0] win_1,
   output logic [DATA_W-1:0] win_2,
   output logic [DATA_W-1:0] win_3,
   output logic [DATA_W-1:0] win_4,
   output logic [DATA_W-1:0] win_5,
   output logic [DATA_W-1:0] win_6,
   output logic [DATA_W-1:0] win_7,
   output logic [DATA_W-1:0] win_8,
   output logic              win_valid,
   output logic              frame_done
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_lb0 [IMG_W];   // row r-2
   logic [DATA_W-1:0] r_lb1 [IMG_W];   // row r-1
   logic [DATA_W-1:0] r_win [9];
   logic              r_win_valid;
   logic              r_frame_done;

   logic [DATA_W-1:0] w_lb0_rd;
   logic [DATA_W-1:0] w_lb1_rd;
   logic              w_col_last;
   logic              w_row_last;
   logic              w_win_done;

   assign w_lb0_rd   = r_lb0[r_col];
   assign w_lb1_rd   = r_lb1[r_col];
   assign w_col_last = (r_col == CW'(IMG_W - 1));
   assign w_row_last = (r_row == RW'(IMG_H - 1));
   // All three window columns belong to the current row triple once col>=2.
   assign w_win_done = (r_row >= RW'(2)) && (r_col >= CW'(2));

   // Line buffers: read-before-write at the current column; contents are
   // never reset because emission waits until both rows are rewritten.
   always_ff @(posedge clk) begin
      if (pixel_valid) begin
         r_lb0[r_col] <= w_lb1_rd;
         r_lb1[r_col] <= pixel_in;
      end
   end

   // Raster counters, window shift register and the output strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int unsigned i = 0; i < 9; i++) begin
            r_win[i] <= '0;
         end
      end else begin
         r_win_valid  <= pixel_valid && w_win_done;
         r_frame_done <= pixel_valid && w_col_last && w_row_last;
         if (pixel_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb0_rd;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb1_rd;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pixel_in;
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   assign win_0      = r_win[0];
   assign win_1      = r_win[1];
   assign win_2      = r_win[2];
   assign win_3      = r_win[3];
   assign win_4      = r_win[4];
   assign win_5      = r_win[5];
   assign win_6      = r_win[6];
   assign win_7      = r_win[7];
   assign win_8      = r_win[8];
   assign win_valid  = r_win_valid;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen: a 5x4 instance for the directed frame,
// gap, back-to-back and mid-frame reset cases, and a 28x28 instance fed
// random pixels. Expected windows come from a per-frame image array.
module tb_conv_window_gen;

   localparam int SW = 5;
   localparam int SH = 4;
   localparam int BW = 28;
   localparam int BH = 28;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic        rst_s = 1'b0;
   logic        pv_s = 1'b0;
   logic [31:0] pd_s = '0;
   logic [31:0] ws [0:8];
   logic        wv_s, fd_s;

   // large instance
   logic        rst_b = 1'b0;
   logic        pv_b = 1'b0;
   logic [31:0] pd_b = '0;
   logic [31:0] wb [0:8];
   logic        wv_b, fd_b;

   conv_window_gen #(.DATA_W(32), .IMG_W(SW), .IMG_H(SH)) u_small (
      .clk(clk), .rst(rst_s), .pixel_valid(pv_s), .pixel_in(pd_s),
      .win_0(ws[0]), .win_1(ws[1]), .win_2(ws[2]), .win_3(ws[3]), .win_4(ws[4]),
      .win_5(ws[5]), .win_6(ws[6]), .win_7(ws[7]), .win_8(ws[8]),
      .win_valid(wv_s), .frame_done(fd_s)
   );

   conv_window_gen #(.DATA_W(32), .IMG_W(BW), .IMG_H(BH)) u_big (
      .clk(clk), .rst(rst_b), .pixel_valid(pv_b), .pixel_in(pd_b),
      .win_0(wb[0]), .win_1(wb[1]), .win_2(wb[2]), .win_3(wb[3]), .win_4(wb[4]),
      .win_5(wb[5]), .win_6(wb[6]), .win_7(wb[7]), .win_8(wb[8]),
      .win_valid(wv_b), .frame_done(fd_b)
   );

   int n_checks = 0;
   int n_err    = 0;

   // reference model state: pixel index within the frame plus the frame image
   int          k_s = 0;
   int          k_b = 0;
   logic [31:0] img_s [0:SH-1][0:SW-1];
   logic [31:0] img_b [0:BH-1][0:BW-1];
   int          nwin_s = 0, nfd_s = 0;
   int          nwin_b = 0, nfd_b = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_s(input logic v, input logic [31:0] d);
      int r, c;
      logic ev, ef;
      @(negedge clk);
      pv_s = v;
      pd_s = d;
      r  = k_s / SW;
      c  = k_s % SW;
      ev = 1'b0;
      ef = 1'b0;
      if (v) begin
         img_s[r][c] = d;
         ev  = (r >= 2) && (c >= 2);
         ef  = (k_s == SW * SH - 1);
         k_s = (k_s + 1) % (SW * SH);
      end
      @(posedge clk);
      #1;
      chk("s_win_valid", 32'(wv_s), 32'(ev));
      chk("s_frame_done", 32'(fd_s), 32'(ef));
      if (wv_s) nwin_s++;
      if (fd_s) nfd_s++;
      if (ev) begin
         for (int i = 0; i < 9; i++)
            chk("s_win", ws[i], img_s[r - 2 + i / 3][c - 2 + i % 3]);
      end
   endtask

   task automatic step_b(input logic v, input logic [31:0] d);
      int r, c;
      logic ev, ef;
      @(negedge clk);
      pv_b = v;
      pd_b = d;
      r  = k_b / BW;
      c  = k_b % BW;
      ev = 1'b0;
      ef = 1'b0;
      if (v) begin
         img_b[r][c] = d;
         ev  = (r >= 2) && (c >= 2);
         ef  = (k_b == BW * BH - 1);
         k_b = (k_b + 1) % (BW * BH);
      end
      @(posedge clk);
      #1;
      chk("b_win_valid", 32'(wv_b), 32'(ev));
      chk("b_frame_done", 32'(fd_b), 32'(ef));
      if (wv_b) nwin_b++;
      if (fd_b) nfd_b++;
      if (ev) begin
         for (int i = 0; i < 9; i++)
            chk("b_win", wb[i], img_b[r - 2 + i / 3][c - 2 + i % 3]);
      end
   endtask

   // Window of a 5-wide frame whose top-left pixel value is 'base'.
   task automatic chk_const_win(input string tag, input int base);
      int off [9];
      off = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      for (int i = 0; i < 9; i++)
         chk(tag, ws[i], 32'(base + off[i]));
   endtask

   task automatic chk_zero_s(input string tag);
      for (int i = 0; i < 9; i++) chk(tag, ws[i], 32'd0);
      chk(tag, 32'(wv_s), 32'd0);
      chk(tag, 32'(fd_s), 32'd0);
   endtask

   initial begin
      int w0, f0;

      // reset both instances
      repeat (3) @(posedge clk);
      #1;
      chk_zero_s("reset_small");
      for (int i = 0; i < 9; i++) chk("reset_big", wb[i], 32'd0);
      chk("reset_big_valid", 32'(wv_b), 32'd0);
      @(negedge clk);
      rst_s = 1'b1;
      rst_b = 1'b1;

      // frame A: 0..19 continuous
      w0 = nwin_s; f0 = nfd_s;
      for (int p = 0; p < 20; p++) begin
         step_s(1'b1, 32'(p));
         if (p == 12) chk_const_win("a_first_win", 0);
         if (p == 19) begin
            chk_const_win("a_last_win", 7);
            chk("a_last_fd", 32'(fd_s), 32'd1);
         end
      end
      step_s(1'b0, 32'hdead_beef);
      chk("a_nwin", 32'(nwin_s - w0), 32'd6);
      chk("a_nfd", 32'(nfd_s - f0), 32'd1);

      // frame B: 0..19 with ~40% gaps
      w0 = nwin_s; f0 = nfd_s;
      for (int p = 0; p < 20; p++) begin
         while ($urandom_range(99) < 40) step_s(1'b0, $urandom);
         step_s(1'b1, 32'(p));
      end
      step_s(1'b0, $urandom);
      chk("b_gap_nwin", 32'(nwin_s - w0), 32'd6);
      chk("b_gap_nfd", 32'(nfd_s - f0), 32'd1);

      // frame C: 100..119 right after frame B
      w0 = nwin_s;
      for (int p = 0; p < 20; p++) begin
         step_s(1'b1, 32'(100 + p));
         if (p == 12) chk_const_win("c_first_win", 100);
      end
      chk("c_nwin", 32'(nwin_s - w0), 32'd6);

      // mid-frame asynchronous reset after pixel 13, then restart at 200
      for (int p = 0; p < 14; p++) step_s(1'b1, 32'(p));
      chk("pre_rst_valid", 32'(wv_s), 32'd1);
      #2;
      rst_s = 1'b0;
      #1;
      chk_zero_s("async_rst");
      @(negedge clk);
      pv_s  = 1'b0;
      rst_s = 1'b1;
      k_s   = 0;
      w0 = nwin_s;
      for (int p = 0; p < 20; p++) begin
         step_s(1'b1, 32'(200 + p));
         if (p == 12) chk_const_win("r_first_win", 200);
      end
      chk("r_nwin", 32'(nwin_s - w0), 32'd6);
      step_s(1'b0, 32'd0);

      // 28x28 random frame with random gaps
      for (int p = 0; p < BW * BH; p++) begin
         while ($urandom_range(99) < 25) step_b(1'b0, $urandom);
         step_b(1'b1, $urandom);
      end
      step_b(1'b0, 32'd0);
      step_b(1'b0, 32'd0);
      chk("big_nwin", 32'(nwin_b), 32'd676);
      chk("big_nfd", 32'(nfd_b), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
